// File: rtl/l2_fence_drain_ctrl.sv
// l2_fence_drain_ctrl: sequences L2 fences and full-cache drains
module l2_fence_drain_ctrl #(
    parameter int L2_SETS = 256,
    parameter int L2_WAYS = 8,
    parameter int N_MSHR = 4,
    localparam int SET_BITS = $clog2(L2_SETS),
    localparam int WAY_BITS = $clog2(L2_WAYS),
    localparam int CNT_BITS = $clog2(N_MSHR) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fence_start,
    input  logic                fence_drain,
    input  logic [CNT_BITS-1:0] mshr_cnt,
    input  logic                drain_req_ready,
    input  logic                clr_ongoing_drain,
    output logic                drain_req_valid,
    output logic [SET_BITS-1:0] drain_set,
    output logic [WAY_BITS-1:0] drain_way,
    output logic                ongoing_fence,
    output logic                drain_in_progress,
    output logic                ongoing_drain,
    output logic                fence_done,
    output logic [2:0]          state_dbg
);
    localparam int IDX_BITS = SET_BITS + WAY_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(L2_SETS * L2_WAYS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_MSHR  = 3'd1,
        DRAIN      = 3'd2,
        FLUSH_WAIT = 3'd3,
        DONE       = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_BITS-1:0] idx_q, idx_d;
    logic                ongoing_drain_q, ongoing_drain_d;
    logic                drain_kind_q, drain_kind_d;
    logic                mshr_free, accept, set_drain;

    // next-state, walk index and status outputs
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        drain_kind_d      = drain_kind_q;
        set_drain         = 1'b0;
        mshr_free         = mshr_cnt == CNT_BITS'(N_MSHR);
        drain_req_valid   = state_q == DRAIN && mshr_cnt != '0;
        accept            = drain_req_valid && drain_req_ready;
        drain_in_progress = state_q == DRAIN || state_q == FLUSH_WAIT;
        ongoing_fence     = state_q != IDLE;
        fence_done        = state_q == DONE;
        state_dbg         = state_q;
        drain_set         = idx_q[IDX_BITS-1:WAY_BITS];
        drain_way         = idx_q[WAY_BITS-1:0];
        case (state_q)
            IDLE: begin
                if (fence_start) begin
                    drain_kind_d = fence_drain;
                    state_d      = WAIT_MSHR;
                end
            end
            WAIT_MSHR: begin
                if (mshr_free) begin
                    state_d   = drain_kind_q ? DRAIN : DONE;
                    set_drain = drain_kind_q;
                end
            end
            DRAIN: begin
                if (accept) begin
                    idx_d   = idx_q == LAST_IDX ? '0 : idx_q + IDX_BITS'(1);
                    state_d = idx_q == LAST_IDX ? FLUSH_WAIT : DRAIN;
                end
            end
            FLUSH_WAIT: state_d = mshr_free ? DONE : FLUSH_WAIT;
            default:    state_d = IDLE;
        endcase
        ongoing_drain_d = set_drain ? 1'b1 :
                          (clr_ongoing_drain && !drain_in_progress) ? 1'b0 : ongoing_drain_q;
        ongoing_drain   = ongoing_drain_q;
    end

    // state registers with synchronous reset aborting any fence
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            ongoing_drain_q <= 1'b0;
            drain_kind_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            ongoing_drain_q <= ongoing_drain_d;
            drain_kind_q    <= drain_kind_d;
        end
    end
endmodule

// File: tb/tb_l2_fence_drain_ctrl.sv
// tb_l2_fence_drain_ctrl: vector, directed and random checks against a line-queue model
module tb_l2_fence_drain_ctrl;
    localparam int S = 4;
    localparam int W = 2;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst, fence_start, fence_drain, drain_req_ready, clr_ongoing_drain;
    logic [2:0] mshr_cnt;
    logic       drain_req_valid, ongoing_fence, drain_in_progress, ongoing_drain, fence_done;
    logic [1:0] drain_set;
    logic [0:0] drain_way;
    logic [2:0] state_dbg;

    l2_fence_drain_ctrl #(.L2_SETS(S), .L2_WAYS(W), .N_MSHR(N)) dut (
        .clk(clk), .rst(rst), .fence_start(fence_start), .fence_drain(fence_drain),
        .mshr_cnt(mshr_cnt), .drain_req_ready(drain_req_ready),
        .clr_ongoing_drain(clr_ongoing_drain), .drain_req_valid(drain_req_valid),
        .drain_set(drain_set), .drain_way(drain_way), .ongoing_fence(ongoing_fence),
        .drain_in_progress(drain_in_progress), .ongoing_drain(ongoing_drain),
        .fence_done(fence_done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {int s; int w;} line_t;
    typedef struct {
        bit fs; bit fd; int mc; bit rdy; bit clr; bit r;
        int st; bit done; bit val; bit of; bit od;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    int    dones = 0;
    int    ph = 0;
    bit    m_kind = 0;
    bit    m_od = 0;
    line_t wq[$];
    line_t acc_q[$];
    vec_t  tbl[13];

    task automatic chk(string nm, logic [31:0] a, int e);
        checks++;
        if (a !== 32'(e)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // phases: 0 idle, 1 awaiting MSHRs, 2 walking lines, 3 awaiting flush, 4 completing
    task automatic model_step(bit fs, bit fd, int mc, bit rdy, bit clr, bit r);
        bit walking;
        walking = ph == 2 || ph == 3;
        if (r) begin
            ph = 0; m_od = 0; m_kind = 0; wq.delete();
        end else begin
            if (ph == 1 && mc == N && m_kind) m_od = 1;
            else if (clr && !walking) m_od = 0;
            case (ph)
                0: if (fs) begin m_kind = fd; ph = 1; end
                1: if (mc == N) begin
                    if (m_kind) begin
                        ph = 2;
                        for (int s = 0; s < S; s++)
                            for (int w = 0; w < W; w++) wq.push_back('{s, w});
                    end else ph = 4;
                end
                2: if (mc != 0 && rdy) begin
                    void'(wq.pop_front());
                    if (wq.size() == 0) ph = 3;
                end
                3: if (mc == N) ph = 4;
                default: ph = 0;
            endcase
        end
    endtask

    task automatic drive(bit fs, bit fd, int mc, bit rdy, bit clr, bit r);
        fence_start = fs; fence_drain = fd; mshr_cnt = 3'(mc);
        drain_req_ready = rdy; clr_ongoing_drain = clr; rst = r;
        #1;
        chk("state_dbg", state_dbg, ph);
        chk("ongoing_fence", ongoing_fence, int'(ph != 0));
        chk("drain_in_progress", drain_in_progress, int'(ph == 2 || ph == 3));
        chk("ongoing_drain", ongoing_drain, int'(m_od));
        chk("fence_done", fence_done, int'(ph == 4));
        chk("drain_req_valid", drain_req_valid, int'(ph == 2 && mc != 0));
        chk("drain_set", drain_set, ph == 2 ? wq[0].s : 0);
        chk("drain_way", drain_way, ph == 2 ? wq[0].w : 0);
        if (drain_req_valid === 1'b1 && rdy) acc_q.push_back('{int'(drain_set), int'(drain_way)});
        if (fence_done === 1'b1) dones++;
    endtask

    task automatic cyc(bit fs, bit fd, int mc, bit rdy, bit clr, bit r);
        drive(fs, fd, mc, rdy, clr, r);
        @(posedge clk);
        model_step(fs, fd, mc, rdy, clr, r);
        @(negedge clk);
    endtask

    task automatic run_to_done(string nm);
        for (int k = 0; k < 60 && dones == 0; k++) cyc(0, 0, 4, 1, 0, 0);
        chk(nm, dones, 1);
    endtask

    initial begin
        fence_start = 0; fence_drain = 0; mshr_cnt = 3'd4;
        drain_req_ready = 0; clr_ongoing_drain = 0; rst = 1;
        @(posedge clk);
        @(negedge clk);

        //        fs fd mc rdy clr r   st done val of od
        tbl[0]  = '{0, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 4, 0, 0, 0,  1, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 4, 0, 0, 0,  4, 1, 0, 1, 0};
        tbl[4]  = '{0, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[5]  = '{1, 0, 2, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[6]  = '{0, 0, 2, 0, 0, 0,  1, 0, 0, 1, 0};
        tbl[7]  = '{0, 0, 2, 0, 0, 0,  1, 0, 0, 1, 0};
        tbl[8]  = '{0, 0, 2, 0, 0, 0,  1, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 2, 0, 0, 0,  1, 0, 0, 1, 0};
        tbl[10] = '{0, 0, 4, 0, 0, 0,  1, 0, 0, 1, 0};
        tbl[11] = '{0, 0, 4, 0, 0, 0,  4, 1, 0, 1, 0};
        tbl[12] = '{0, 0, 4, 0, 0, 0,  0, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].fs, tbl[i].fd, tbl[i].mc, tbl[i].rdy, tbl[i].clr, tbl[i].r);
            chk($sformatf("vec%0d_state", i), state_dbg, tbl[i].st);
            chk($sformatf("vec%0d_done", i), fence_done, int'(tbl[i].done));
            chk($sformatf("vec%0d_valid", i), drain_req_valid, int'(tbl[i].val));
            chk($sformatf("vec%0d_fence", i), ongoing_fence, int'(tbl[i].of));
            chk($sformatf("vec%0d_odrain", i), ongoing_drain, int'(tbl[i].od));
            @(posedge clk);
            model_step(tbl[i].fs, tbl[i].fd, tbl[i].mc, tbl[i].rdy, tbl[i].clr, tbl[i].r);
            @(negedge clk);
        end

        // full drain with ready held high
        acc_q.delete(); dones = 0;
        cyc(1, 1, 4, 1, 0, 0);
        run_to_done("full_drain_done");
        chk("full_drain_count", acc_q.size(), 8);
        for (int i = 0; i < acc_q.size() && i < 8; i++) begin
            chk($sformatf("order%0d_set", i), acc_q[i].s, i / 2);
            chk($sformatf("order%0d_way", i), acc_q[i].w, i % 2);
        end
        cyc(0, 0, 4, 0, 0, 0);
        chk("odrain_held", ongoing_drain, 1);
        cyc(0, 0, 4, 0, 1, 0);
        chk("odrain_cleared", ongoing_drain, 0);

        // backpressure and MSHR starvation at idx 5
        acc_q.delete(); dones = 0;
        cyc(1, 1, 4, 1, 0, 0);
        for (int k = 0; k < 40 && acc_q.size() < 5; k++) cyc(0, 0, 4, 1, 0, 0);
        chk("bp_reach_idx5", acc_q.size(), 5);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 4, 0, 0, 0);
            chk("bp_set", drain_set, 2);
            chk("bp_way", drain_way, 1);
            chk("bp_valid", drain_req_valid, 1);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 1, 0, 0);
            chk("starve_valid", drain_req_valid, 0);
            chk("starve_set", drain_set, 2);
            chk("starve_way", drain_way, 1);
        end
        chk("starve_no_advance", acc_q.size(), 5);
        run_to_done("bp_done");
        cyc(0, 0, 4, 0, 1, 0);

        // reset in the middle of a walk
        acc_q.delete(); dones = 0;
        cyc(1, 1, 4, 1, 0, 0);
        for (int k = 0; k < 40 && acc_q.size() < 3; k++) cyc(0, 0, 4, 1, 0, 0);
        chk("rst_reach_idx3", acc_q.size(), 3);
        cyc(0, 0, 4, 0, 0, 1);
        chk("rst_state", state_dbg, 0);
        chk("rst_fence", ongoing_fence, 0);
        chk("rst_dip", drain_in_progress, 0);
        chk("rst_odrain", ongoing_drain, 0);
        chk("rst_valid", drain_req_valid, 0);
        chk("rst_set", drain_set, 0);
        chk("rst_way", drain_way, 0);
        chk("rst_no_done", dones, 0);
        acc_q.delete();
        cyc(1, 1, 4, 1, 0, 0);
        cyc(0, 0, 4, 1, 0, 0);
        chk("restart_valid", drain_req_valid, 1);
        chk("restart_set", drain_set, 0);
        chk("restart_way", drain_way, 0);
        run_to_done("restart_done");
        cyc(0, 0, 4, 0, 1, 0);

        // fence_start and clr_ongoing_drain during the walk are ignored
        acc_q.delete(); dones = 0;
        cyc(1, 1, 4, 1, 0, 0);
        for (int k = 0; k < 40 && acc_q.size() < 2; k++) cyc(0, 0, 4, 1, 0, 0);
        cyc(1, 0, 4, 1, 1, 0);
        chk("ign_odrain", ongoing_drain, 1);
        chk("ign_state", state_dbg, 2);
        run_to_done("ign_done");
        for (int k = 0; k < 4; k++) cyc(0, 0, 4, 1, 0, 0);
        chk("ign_single_done", dones, 1);
        chk("ign_idle", state_dbg, 0);
        chk("ign_lines", acc_q.size(), 8);

        // random stimulus against the model
        for (int k = 0; k < 1500; k++) begin
            int m;
            m = $urandom_range(0, 6);
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, m > 4 ? 4 : m,
                $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 120) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
